sync_fifo_prog: RTL
===================

Name: sync_fifo_prog

Overview:
Parametrised synchronous FIFO that generalises the team's fixed FIFO.
- Configurable width and depth; depth need not be a power of two.
- Programmable almost-full/almost-empty thresholds and an occupancy count output.
- Synchronous flush input.
- Standard (registered-read) or first-word-fall-through (FWFT) output mode.
- Drop-in buffer between producer/consumer blocks on a single clock domain; verified with the existing FIFO_if-style class-based bench.

Parameters:
FIFO_WIDTH, 16, data word width in bits (≥1)
FIFO_DEPTH, 8, number of storage entries (≥2, any integer)
FWFT, 0, 0 = standard read (data_out updates one cycle after an accepted read); 1 = head word always presented on data_out
CW (localparam), $clog2(FIFO_DEPTH+1), width of level and threshold ports

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear, highest priority
wr_en  in  1  write request
data_in  in  FIFO_WIDTH  write data
rd_en  in  1  read request
afull_thresh  in  CW  almostfull asserted when level ≥ this value
aempty_thresh  in  CW  almostempty asserted when level ≤ this value
data_out  out  FIFO_WIDTH  read data
full  out  1  level == FIFO_DEPTH
empty  out  1  level == 0
almostfull  out  1  level ≥ afull_thresh
almostempty  out  1  level ≤ aempty_thresh
level  out  CW  current occupancy, 0..FIFO_DEPTH
wr_ack  out  1  registered; previous-cycle write accepted
overflow  out  1  registered; previous-cycle write rejected
underflow  out  1  registered; previous-cycle read rejected

Behaviour:
Reset (rst_n=0, asynchronous):
- wr_ptr=0, rd_ptr=0, level=0, data_out=0; wr_ack/overflow/underflow=0.
- empty=1, full=0.
- almostempty/almostfull follow their threshold compare against level=0.
- Memory contents are not reset.

Status flags:
- full, empty, almostfull, almostempty are combinational from the level register and threshold inputs.
- Thresholds are compared every cycle; there is no latching.

Accept rules, evaluated each rising edge with flush=0:
- wr_acc = wr_en & (!full | rd_en). At full, a simultaneous read frees a slot; both are accepted and level is unchanged.
- rd_acc = rd_en & !empty. At empty, a simultaneous write is accepted and the read is rejected.
- On wr_acc: mem[wr_ptr] ← data_in; wr_ptr advances.
- On rd_acc: rd_ptr advances.
- Level update: level += wr_acc − rd_acc.
- Pointer wrap: a pointer at FIFO_DEPTH−1 goes to 0 (modulo FIFO_DEPTH, not a binary wrap).

Handshake responses (next cycle):
- wr_ack = wr_acc.
- overflow = wr_en & !wr_acc.
- underflow = rd_en & !rd_acc.
- All three are single-cycle pulses, never sticky.

Output mode, FWFT=0:
- On rd_acc, data_out ← mem[rd_ptr] at the same edge, visible the cycle after rd_en.
- Otherwise data_out holds its value.

Output mode, FWFT=1:
- data_out = mem[rd_ptr] whenever !empty.
- data_out = 0 when empty.
- A word written into an empty FIFO appears on data_out the cycle after its write.

Flush:
- flush=1 clears pointers and level at the edge.
- Forces wr_ack/overflow/underflow to 0 next cycle.
- wr_en/rd_en are ignored that cycle.
- In FWFT=0, data_out holds its value.

Reset mid-operation:
- Immediate return to reset values; all in-flight requests are dropped.

Decomposition:
shared_pkg:
- Default FIFO_WIDTH/FIFO_DEPTH constants.
- Enum fifo_mode_e {STD, FWFT}.

Sub-module fifo_mem:
- Parameters FIFO_WIDTH, FIFO_DEPTH.
- One synchronous write port and one asynchronous read port.
- Instantiated once.

Pointer/level/flag logic stays in sync_fifo_prog.

Test Plan (FIFO_WIDTH=16, FIFO_DEPTH=6 unless noted):
1. Reset then idle -> level=0, empty=1, full=0, wr_ack/overflow/underflow=0, data_out=0.
2. Write 6 words 0x0A00..0x0A05 → wrap; read 6 → write 0x0B00..0x0B02 -> data_out sequence is 0x0A00..0x0A05 then 0x0B00..; pointers wrap 5→0 with no data loss.
3. Fill to 6, then wr_en=1 alone -> overflow=1, wr_ack=0, level=6. Next, wr_en=rd_en=1 -> wr_ack=1, level stays 6, oldest word popped.
4. Empty FIFO, rd_en=wr_en=1 with data 0x1234 -> underflow=1, wr_ack=1, level=1. FWFT=1: data_out=0x1234 the next cycle.
5. afull_thresh=4, aempty_thresh=1; step level 0→6→0 -> almostempty=1 for level≤1, almostfull=1 for level≥4, both exact at boundaries.
6. Level 3: assert flush with wr_en=1; separately assert rst_n=0 mid-burst -> level=0, empty=1, no wr_ack for the flushed write; async reset clears outputs without a clock edge.

Source files
------------

// File: rtl/shared_pkg.sv
// Shared types and default sizes for the programmable FIFO slice.
package shared_pkg;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 8;

  typedef enum logic {
    STD,
    FWFT
  } fifo_mode_e;

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Producer/consumer bundle for sync_fifo_prog.
interface sync_fifo_prog_if
  import shared_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                  flush;
  logic                  wr_en;
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [CW-1:0]         afull_thresh;
  logic [CW-1:0]         aempty_thresh;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CW-1:0]         level;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_en, data_in, rd_en,
    output afull_thresh, aempty_thresh,
    input  data_out, full, empty,
    input  almostfull, almostempty, level,
    input  wr_ack, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en,
    input  afull_thresh, aempty_thresh,
    output data_out, full, empty,
    output almostfull, almostempty, level,
    output wr_ack, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
module fifo_mem
  import shared_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int AW = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [FIFO_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [FIFO_WIDTH-1:0] rdata
);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  // Contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO, any depth, programmable thresholds, STD or FWFT read.
module sync_fifo_prog #(
  parameter int FIFO_WIDTH = shared_pkg::DEF_FIFO_WIDTH,
  parameter int FIFO_DEPTH = shared_pkg::DEF_FIFO_DEPTH,
  parameter int FWFT = 0
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_prog_if.slave bus
);
  import shared_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam fifo_mode_e MODE =
    (FWFT != 0) ? shared_pkg::FWFT : STD;
  localparam logic [CW-1:0] DEPTH_L = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST = AW'(FIFO_DEPTH - 1);

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         level;
  logic                  full;
  logic                  empty;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  mem_we;
  logic [FIFO_WIDTH-1:0] rdata;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;

  // Modulo-depth increment; depth need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(
    input logic [AW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full  = (level == DEPTH_L);
  assign empty = (level == '0);

  always_comb begin
    wr_acc = bus.wr_en & (~full | bus.rd_en);
    rd_acc = bus.rd_en & ~empty;
    mem_we = wr_acc & ~bus.flush;
  end

  fifo_mem #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({wr_acc, rd_acc})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      wr_ack    <= wr_acc;
      overflow  <= bus.wr_en & ~wr_acc;
      underflow <= bus.rd_en & ~rd_acc;
    end
  end

  generate
    if (MODE == STD) begin : g_std
      logic [FIFO_WIDTH-1:0] dout_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q <= '0;
        end else if (!bus.flush && rd_acc) begin
          dout_q <= rdata;
        end
      end

      assign bus.data_out = dout_q;
    end else begin : g_fwft
      assign bus.data_out = empty ? '0 : rdata;
    end
  endgenerate

  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almostfull  = (level >= bus.afull_thresh);
  assign bus.almostempty = (level <= bus.aempty_thresh);
  assign bus.level       = level;
  assign bus.wr_ack      = wr_ack;
  assign bus.overflow    = overflow;
  assign bus.underflow   = underflow;

endmodule
